// File: rtl/serial_rx8.sv
// Serial byte receiver: start, 8 data bits LSB first, stop.
// Holds the last good byte with a full/ack handshake and overrun flag.
module serial_rx8 (
    input  logic       MasterClock,
    input  logic       RESETL,
    input  logic       BITEN,
    input  logic       SDIN,
    input  logic       ACK,
    output logic [7:0] Q,
    output logic       FULL,
    output logic       STB,
    output logic       FERR,
    output logic       OVR,
    output logic       ALLONE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_STOP  = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  q_q, q_d;
    logic        full_q, full_d;
    logic        stb_q, stb_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        allone_q, allone_d;

    always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'h00;
            cnt_q    <= 3'd0;
            q_q      <= 8'h00;
            full_q   <= 1'b0;
            stb_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            allone_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            full_q   <= full_d;
            stb_q    <= stb_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            allone_q <= allone_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        full_d   = full_q;
        ovr_d    = ovr_q;
        allone_d = allone_q;
        stb_d    = 1'b0;
        ferr_d   = 1'b0;

        // Acknowledge first so a coincident good frame overrides it
        if (ACK) begin
            full_d = 1'b0;
            ovr_d  = 1'b0;
        end

        if (BITEN) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!SDIN) begin
                        state_d = S_DATA;
                        cnt_d   = 3'd0;
                        shift_d = 8'h00;
                    end
                end
                S_DATA: begin
                    shift_d[cnt_q] = SDIN;
                    // Wraps 7 -> 0 so the counter leaves DATA at zero
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (SDIN) begin
                        q_d      = shift_q;
                        allone_d = &shift_q;
                        stb_d    = 1'b1;
                        full_d   = 1'b1;
                        if (full_q && !ACK) begin
                            ovr_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (SDIN) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    assign Q      = q_q;
    assign FULL   = full_q;
    assign STB    = stb_q;
    assign FERR   = ferr_q;
    assign OVR    = ovr_q;
    assign ALLONE = allone_q;

endmodule

// File: tb/tb_serial_rx8.sv
// Directed bench for serial_rx8: framing, handshake, overrun,
// framing error with held-low line, reset abort, back-to-back frames.
module tb_serial_rx8;

    logic       clk;
    logic       RESETL;
    logic       BITEN;
    logic       SDIN;
    logic       ACK;
    logic [7:0] Q;
    logic       FULL;
    logic       STB;
    logic       FERR;
    logic       OVR;
    logic       ALLONE;

    int ncmp;
    int nbad;
    int stb_cnt;
    int ferr_cnt;

    serial_rx8 dut (
        .MasterClock(clk),
        .RESETL(RESETL),
        .BITEN(BITEN),
        .SDIN(SDIN),
        .ACK(ACK),
        .Q(Q),
        .FULL(FULL),
        .STB(STB),
        .FERR(FERR),
        .OVR(OVR),
        .ALLONE(ALLONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (STB === 1'b1) stb_cnt++;
        if (FERR === 1'b1) ferr_cnt++;
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit-time strobe; returns at the negedge after the sampling edge
    task automatic strobe(input logic b, input logic ack);
        SDIN  = b;
        BITEN = 1'b1;
        ACK   = ack;
        @(negedge clk);
        BITEN = 1'b0;
        ACK   = 1'b0;
    endtask

    // Start bit and 8 data bits, each followed by g idle clocks
    task automatic send_body(input logic [7:0] d, input int g);
        strobe(1'b0, 1'b0);
        gap(g);
        for (int i = 0; i < 8; i++) begin
            strobe(d[i], 1'b0);
            gap(g);
        end
    endtask

    task automatic pulse_ack();
        ACK = 1'b1;
        @(negedge clk);
        ACK = 1'b0;
    endtask

    task automatic test_reset();
        RESETL = 1'b0;
        BITEN  = 1'b1;
        ACK    = 1'b1;
        SDIN   = 1'b0;
        gap(2);
        ncmp++;
        if ({Q, FULL, STB, FERR, OVR, ALLONE} !== 13'd0) begin
            nbad++;
            $display("FAIL reset_outs got %h req 0",
                     {Q, FULL, STB, FERR, OVR, ALLONE});
        end
        RESETL = 1'b1;
        BITEN  = 1'b0;
        ACK    = 1'b0;
        SDIN   = 1'b1;
        gap(2);
    endtask

    task automatic test_a5();
        strobe(1'b1, 1'b0);
        gap(3);
        strobe(1'b1, 1'b0);
        gap(3);
        send_body(8'hA5, 3);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({STB, FERR, FULL, ALLONE} !== 4'b1010) begin
            nbad++;
            $display("FAIL a5_flags got %b req 1010",
                     {STB, FERR, FULL, ALLONE});
        end
        ncmp++;
        if (Q !== 8'hA5) begin
            nbad++;
            $display("FAIL a5_q got %h req a5", Q);
        end
        gap(1);
        ncmp++;
        if (STB !== 1'b0) begin
            nbad++;
            $display("FAIL a5_stb_width got %b req 0", STB);
        end
        gap(2);
    endtask

    task automatic test_allone();
        send_body(8'hFF, 3);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({Q, ALLONE, STB} !== {8'hFF, 2'b11}) begin
            nbad++;
            $display("FAIL ff_q_allone got %h/%b/%b req ff/1/1",
                     Q, ALLONE, STB);
        end
        gap(2);
        pulse_ack();
        ncmp++;
        if ({FULL, OVR} !== 2'b00) begin
            nbad++;
            $display("FAIL ff_ack got %b req 00", {FULL, OVR});
        end
        gap(2);
        send_body(8'h7F, 3);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({Q, ALLONE, FULL, OVR} !== {8'h7F, 3'b010}) begin
            nbad++;
            $display("FAIL 7f_q_allone got %h/%b/%b/%b req 7f/0/1/0",
                     Q, ALLONE, FULL, OVR);
        end
        gap(3);
    endtask

    task automatic test_ferr();
        int f0;
        int s0;
        f0 = ferr_cnt;
        s0 = stb_cnt;
        send_body(8'h3C, 3);
        strobe(1'b0, 1'b0);
        ncmp++;
        if ({FERR, STB, Q, FULL} !== {2'b10, 8'h7F, 1'b1}) begin
            nbad++;
            $display("FAIL ferr_pulse got %b/%b/%h/%b req 1/0/7f/1",
                     FERR, STB, Q, FULL);
        end
        gap(1);
        ncmp++;
        if (FERR !== 1'b0) begin
            nbad++;
            $display("FAIL ferr_width got %b req 0", FERR);
        end
        for (int i = 0; i < 12; i++) begin
            strobe(1'b0, 1'b0);
            gap(3);
        end
        strobe(1'b1, 1'b0);
        gap(3);
        ncmp++;
        if (ferr_cnt - f0 !== 1 || stb_cnt !== s0) begin
            nbad++;
            $display("FAIL ferr_count got %0d/%0d req 1/0",
                     ferr_cnt - f0, stb_cnt - s0);
        end
        pulse_ack();
        send_body(8'h11, 3);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({Q, STB, FERR} !== {8'h11, 2'b10}) begin
            nbad++;
            $display("FAIL ferr_next got %h/%b/%b req 11/1/0",
                     Q, STB, FERR);
        end
        gap(3);
    endtask

    task automatic test_overrun();
        pulse_ack();
        send_body(8'h12, 3);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({FULL, OVR} !== 2'b10) begin
            nbad++;
            $display("FAIL ovr_first got %b req 10", {FULL, OVR});
        end
        gap(3);
        send_body(8'h34, 3);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({Q, FULL, OVR} !== {8'h34, 2'b11}) begin
            nbad++;
            $display("FAIL ovr_set got %h/%b/%b req 34/1/1",
                     Q, FULL, OVR);
        end
        gap(5);
        ncmp++;
        if (OVR !== 1'b1) begin
            nbad++;
            $display("FAIL ovr_sticky got %b req 1", OVR);
        end
        pulse_ack();
        ncmp++;
        if ({FULL, OVR} !== 2'b00) begin
            nbad++;
            $display("FAIL ovr_ack got %b req 00", {FULL, OVR});
        end
        gap(2);
    endtask

    task automatic test_ack_collide();
        send_body(8'h12, 3);
        strobe(1'b1, 1'b0);
        gap(3);
        send_body(8'h56, 3);
        strobe(1'b1, 1'b1);
        ncmp++;
        if ({Q, FULL, OVR, STB} !== {8'h56, 3'b101}) begin
            nbad++;
            $display("FAIL ack_collide got %h/%b/%b/%b req 56/1/0/1",
                     Q, FULL, OVR, STB);
        end
        gap(3);
    endtask

    task automatic test_reset_abort();
        int s0;
        s0 = stb_cnt;
        strobe(1'b0, 1'b0);
        gap(3);
        for (int i = 0; i < 4; i++) begin
            strobe(((8'hC3 >> i) & 8'h01) != 0, 1'b0);
            gap(3);
        end
        RESETL = 1'b0;
        @(negedge clk);
        RESETL = 1'b1;
        ncmp++;
        if ({Q, FULL, STB, FERR, OVR, ALLONE} !== 13'd0) begin
            nbad++;
            $display("FAIL abort_outs got %h req 0",
                     {Q, FULL, STB, FERR, OVR, ALLONE});
        end
        for (int i = 0; i < 6; i++) begin
            strobe(1'b1, 1'b0);
            gap(3);
        end
        ncmp++;
        if (stb_cnt !== s0 || Q !== 8'h00) begin
            nbad++;
            $display("FAIL abort_nostb got %0d/%h req 0/00",
                     stb_cnt - s0, Q);
        end
        send_body(8'h81, 3);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({Q, STB, FULL, OVR} !== {8'h81, 3'b110}) begin
            nbad++;
            $display("FAIL abort_next got %h/%b/%b/%b req 81/1/1/0",
                     Q, STB, FULL, OVR);
        end
        gap(3);
    endtask

    task automatic test_back_to_back();
        pulse_ack();
        send_body(8'hE7, 0);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({Q, STB} !== {8'hE7, 1'b1}) begin
            nbad++;
            $display("FAIL b2b_first got %h/%b req e7/1", Q, STB);
        end
        send_body(8'h0F, 0);
        strobe(1'b1, 1'b0);
        ncmp++;
        if ({Q, STB, OVR, ALLONE} !== {8'h0F, 3'b110}) begin
            nbad++;
            $display("FAIL b2b_second got %h/%b/%b/%b req 0f/1/1/0",
                     Q, STB, OVR, ALLONE);
        end
        gap(3);
    endtask

    initial begin
        ncmp     = 0;
        nbad     = 0;
        stb_cnt  = 0;
        ferr_cnt = 0;
        RESETL   = 1'b0;
        BITEN    = 1'b0;
        SDIN     = 1'b1;
        ACK      = 1'b0;
        @(negedge clk);
        test_reset();
        test_a5();
        test_allone();
        test_ferr();
        test_overrun();
        test_ack_collide();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

endmodule
